// File: rtl/adsr_envelope_gen.sv
// rtl/adsr_envelope_gen.sv - per-voice ADSR envelope generator, one step per Env_ce tick
// Optional exponential release: define ENV_EXP_RELEASE_EN (Release_rate then ignored).
module adsr_envelope_gen #(
    parameter int AMP_W     = 32,
    parameter int REL_SHIFT = 8
) (
    input  logic             Sys_clk,
    input  logic             Env_rst_n,
    input  logic             Env_ce,
    input  logic             Gate,
    input  logic [AMP_W-1:0] Attack_rate,
    input  logic [AMP_W-1:0] Decay_rate,
    input  logic [AMP_W-1:0] Sustain_level,
    input  logic [AMP_W-1:0] Release_rate,
    output logic [AMP_W-1:0] Amplitude,
    output logic             Amp_valid,
    output logic [2:0]       Env_state,
    output logic             Env_active
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ATTACK  = 3'd1;
    localparam logic [2:0] ST_DECAY   = 3'd2;
    localparam logic [2:0] ST_SUSTAIN = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;
    localparam logic [AMP_W-1:0] FULL = '1;

    logic [2:0]       state, next_state;
    logic [AMP_W-1:0] level, next_level;
    logic             prev_gate;
    logic             valid_q;
    logic             rise, fall;
    logic [AMP_W:0]   att_sum;
    logic [AMP_W-1:0] dec_diff;
`ifdef ENV_EXP_RELEASE_EN
    logic [AMP_W-1:0] exp_step;
`endif

    always_ff @(posedge Sys_clk or negedge Env_rst_n) begin
        if (!Env_rst_n) begin
            state     <= ST_IDLE;
            level     <= '0;
            prev_gate <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            valid_q <= Env_ce;
            if (Env_ce) begin
                state     <= next_state;
                level     <= next_level;
                prev_gate <= Gate;
            end
        end
    end

    always_comb begin
        rise       = Gate & ~prev_gate;
        // A low gate in any gated state releases, even if the falling edge itself was missed.
        fall       = ~Gate & ((state == ST_ATTACK) | (state == ST_DECAY) | (state == ST_SUSTAIN));
        att_sum    = {1'b0, level} + {1'b0, Attack_rate};
        dec_diff   = level - Decay_rate;
`ifdef ENV_EXP_RELEASE_EN
        exp_step   = level >> REL_SHIFT;
        if (exp_step == '0)
            exp_step = {{(AMP_W-1){1'b0}}, 1'b1};
`endif
        next_state = state;
        next_level = level;
        if (rise) begin
            next_state = ST_ATTACK;
        end else if (fall) begin
            next_state = ST_RELEASE;
        end else begin
            case (state)
                ST_IDLE: next_level = '0;
                ST_ATTACK: begin
                    if (Attack_rate != '0) begin
                        if (att_sum[AMP_W] || (att_sum[AMP_W-1:0] == FULL)) begin
                            next_level = FULL;
                            next_state = ST_DECAY;
                        end else begin
                            next_level = att_sum[AMP_W-1:0];
                        end
                    end
                end
                ST_DECAY: begin
                    if (Decay_rate != '0) begin
                        if ((Decay_rate > level) || (dec_diff <= Sustain_level)) begin
                            next_level = Sustain_level;
                            next_state = ST_SUSTAIN;
                        end else begin
                            next_level = dec_diff;
                        end
                    end
                end
                ST_SUSTAIN: next_level = Sustain_level;
                ST_RELEASE: begin
`ifdef ENV_EXP_RELEASE_EN
                    if (level <= {{(AMP_W-1){1'b0}}, 1'b1}) begin
                        next_level = '0;
                        next_state = ST_IDLE;
                    end else begin
                        next_level = level - exp_step;
                    end
`else
                    if (Release_rate != '0) begin
                        if (Release_rate >= level) begin
                            next_level = '0;
                            next_state = ST_IDLE;
                        end else begin
                            next_level = level - Release_rate;
                        end
                    end
`endif
                end
                default: begin
                    next_level = '0;
                    next_state = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        Amplitude  = level;
        Amp_valid  = valid_q;
        Env_state  = state;
        Env_active = (state != ST_IDLE);
    end

endmodule
